// File: rtl/alu_txn_driver.sv
// ALU initiator: buffers commands, drives the registered ALU, returns checked results; one result per 3 cycles peak.
// Backpressure: cmd_ready drops when the FIFO is full; rsp_* hold while rsp_valid && !rsp_ready.
module alu_txn_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_opcode,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic [1:0]       alu_opcode,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [4:0]       alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4:0]       rsp_data,
  output logic [1:0]       rsp_opcode,
  output logic             rsp_mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESP} state_t;

  state_t      state, state_next;
  logic [9:0]  fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;
  logic [9:0]  head;
  logic [4:0]  expected;
  logic        mismatch;

  function automatic logic [4:0] golden(input logic [1:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    logic [4:0] r;
    r = '0;
    case (op)
      2'b00:   r = {a[3], a} + {b[3], b};
      2'b01:   r = {a[3], a} - {b[3], b};
      2'b10:   r = ~{a[3], a};
      default: r = {4'b0000, |b};
    endcase
    return r;
  endfunction

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !reset && !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = fifo_mem[rd_ptr[AW-1:0]];
  assign mismatch  = (alu_c != expected);
  assign busy      = (state != IDLE) || !empty;

  // Storage carries no reset; occupancy is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {cmd_opcode, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = DRIVE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_opcode   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      expected     <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_opcode   <= '0;
      rsp_mismatch <= 1'b0;
      err_count    <= '0;
    end else begin
      if (pop) begin
        alu_opcode <= head[9:8];
        alu_a      <= head[7:4];
        alu_b      <= head[3:0];
        expected   <= golden(head[9:8], head[7:4], head[3:0]);
      end
      if (state == CAPTURE) begin
        rsp_data     <= alu_c;
        rsp_opcode   <= alu_opcode;
        rsp_mismatch <= mismatch;
        rsp_valid    <= 1'b1;
        if (mismatch && (err_count != {CNT_W{1'b1}})) err_count <= err_count + CNT_W'(1);
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
